// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scanout slice.
//   vga_timing_t  : one axis of video timing (active / front porch / sync / back porch)
//   VGA_640X480_H : horizontal timing of 640x480@60
//   VGA_640X480_V : vertical timing of 640x480@60
//   rgb_t         : one-bit-per-channel pixel, packed {r,g,b}
//   cnt_width()   : bits needed for a counter that runs 0..total-1
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
    localparam vga_timing_t VGA_640X480_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical) of the VGA raster.
//   clk, rst : clock, asynchronous active-high reset
//   en       : when low the count is held at 0
//   advance  : step the count by one (pixel tick for h, line wrap for v)
//   cnt      : position 0..TOTAL-1
//   active   : cnt is inside the visible region
//   sync     : cnt is inside the sync pulse region (active-high flag)
//   wrap     : advance is set and cnt is at TOTAL-1 (next value is 0)
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    localparam int TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int W     = cnt_width(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         advance,
    output logic [W-1:0] cnt,
    output logic         active,
    output logic         sync,
    output logic         wrap
);

    logic last;

    assign last   = (int'(cnt) == TOTAL - 1);
    assign wrap   = advance && last;
    assign active = (int'(cnt) < ACTIVE);
    assign sync   = (int'(cnt) >= ACTIVE + FP) && (int'(cnt) < ACTIVE + FP + SYNC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA timing generator and framebuffer scanout engine.
//   clk, rst     : system clock, asynchronous active-high reset
//   en           : scanout enable; low holds everything idle at (0,0)
//   fb_addr      : framebuffer read address (line_base + col)
//   fb_rd        : one-clk read strobe, issued once per replicated pixel group
//   fb_data      : {r,g,b} returned SRAM_LATENCY clks after fb_rd
//   vga_r/g/b    : colour outputs, zero outside the visible area
//   vga_hsync/vsync : active-low sync pulses
//   frame_start  : one-clk pulse when pixel (0,0) is driven on the outputs
//   vblank       : high while the driven line is in vertical blanking
//
// Read timing: fb_rd is a strobe with fixed latency, not a handshake. It fires
// on the pixel-tick clk of the first pixel of each 2^S-wide group; fb_data is
// captured exactly SRAM_LATENCY clks later, which lands before the next tick
// as long as SRAM_LATENCY <= CLK_DIV-1. The output stage then consumes the
// latched pixel one tick after the counters were at that position.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = int'(VGA_640X480_H.active),
    parameter int H_FP         = int'(VGA_640X480_H.fp),
    parameter int H_SYNC       = int'(VGA_640X480_H.sync),
    parameter int H_BP         = int'(VGA_640X480_H.bp),
    parameter int V_ACTIVE     = int'(VGA_640X480_V.active),
    parameter int V_FP         = int'(VGA_640X480_V.fp),
    parameter int V_SYNC       = int'(VGA_640X480_V.sync),
    parameter int V_BP         = int'(VGA_640X480_V.bp),
    parameter int CLK_DIV      = 2,
    parameter int SCALE_LOG2   = 2,
    parameter int COLOUR_BITS  = 1,
    parameter int SRAM_LATENCY = 1,
    parameter int FB_A_WIDTH   = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic [FB_A_WIDTH-1:0]    fb_addr,
    output logic                     fb_rd,
    input  logic [3*COLOUR_BITS-1:0] fb_data,
    output logic [COLOUR_BITS-1:0]   vga_r,
    output logic [COLOUR_BITS-1:0]   vga_g,
    output logic [COLOUR_BITS-1:0]   vga_b,
    output logic                     vga_hsync,
    output logic                     vga_vsync,
    output logic                     frame_start,
    output logic                     vblank
);

    localparam int HW    = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW    = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int DW    = cnt_width(CLK_DIV);
    localparam int FB_W  = H_ACTIVE >> SCALE_LOG2;
    localparam int CB    = COLOUR_BITS;
    localparam logic [HW-1:0] H_MASK = HW'((1 << SCALE_LOG2) - 1);
    localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_LOG2) - 1);

    logic [DW-1:0]           div;
    logic                    tick;
    logic [HW-1:0]           h_cnt;
    logic [VW-1:0]           v_cnt;
    logic                    h_active, h_sync, h_wrap;
    logic                    v_active, v_sync, v_wrap;
    logic                    pix_active;
    logic                    h_grp_first, h_grp_last, v_grp_last;
    logic [FB_A_WIDTH-1:0]   line_base, col;
    logic [SRAM_LATENCY-1:0] rd_pipe;
    logic [3*CB-1:0]         pix;
    logic                    d_active, d_hsync, d_vsync, d_vblank, d_first;

    // Pixel clock enable.
    assign tick = en && (int'(div) == CLK_DIV - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (!en || tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .clk(clk), .rst(rst), .en(en), .advance(tick),
        .cnt(h_cnt), .active(h_active), .sync(h_sync), .wrap(h_wrap)
    );

    vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .clk(clk), .rst(rst), .en(en), .advance(h_wrap),
        .cnt(v_cnt), .active(v_active), .sync(v_sync), .wrap(v_wrap)
    );

    assign pix_active  = h_active && v_active;
    assign h_grp_first = ((h_cnt & H_MASK) == '0);
    assign h_grp_last  = ((h_cnt & H_MASK) == H_MASK);
    assign v_grp_last  = ((v_cnt & V_MASK) == V_MASK);

    // Address = line_base + col, built incrementally so no multiplier is needed.
    // line_base steps by one framebuffer row after the last replicated copy of
    // each row; a frame wrap takes priority and returns it to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            line_base <= '0;
        end else if (!en) begin
            col       <= '0;
            line_base <= '0;
        end else if (tick) begin
            if (h_wrap) begin
                col <= '0;
                if (v_wrap) begin
                    line_base <= '0;
                end else if (v_active && v_grp_last) begin
                    line_base <= line_base + FB_A_WIDTH'(FB_W);
                end
            end else if (pix_active && h_grp_last) begin
                col <= col + 1'b1;
            end
        end
    end

    assign fb_addr = line_base + col;
    assign fb_rd   = tick && pix_active && h_grp_first;

    // Read-return alignment and pixel latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe <= '0;
            pix     <= '0;
        end else if (!en) begin
            rd_pipe <= '0;
            pix     <= '0;
        end else begin
            rd_pipe <= (rd_pipe << 1) | SRAM_LATENCY'(fb_rd);
            if (rd_pipe[SRAM_LATENCY-1]) begin
                pix <= fb_data;
            end
        end
    end

    // Two stages on tick: d_* captures the counter view of the current pixel,
    // the output registers consume it one tick later together with the latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_active    <= 1'b0;
            d_hsync     <= 1'b0;
            d_vsync     <= 1'b0;
            d_vblank    <= 1'b1;
            d_first     <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vblank      <= 1'b1;
            frame_start <= 1'b0;
        end else if (!en) begin
            d_active    <= 1'b0;
            d_hsync     <= 1'b0;
            d_vsync     <= 1'b0;
            d_vblank    <= 1'b1;
            d_first     <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vblank      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && d_first;
            if (tick) begin
                d_active  <= pix_active;
                d_hsync   <= h_sync;
                d_vsync   <= v_sync;
                d_vblank  <= !v_active;
                d_first   <= (h_cnt == '0) && (v_cnt == '0);
                vga_r     <= d_active ? pix[3*CB-1:2*CB] : '0;
                vga_g     <= d_active ? pix[2*CB-1:CB]   : '0;
                vga_b     <= d_active ? pix[CB-1:0]      : '0;
                vga_hsync <= !d_hsync;
                vga_vsync <= !d_vsync;
                vblank    <= d_vblank;
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two instances on a small raster (H 8/1/2/1, V 4/1/1/1,
// CLK_DIV 2, SRAM_LATENCY 1), one with no pixel replication and one with 2x2.
// Each instance reads its own randomly filled framebuffer model.
module tb_vga_scanout;

    localparam int HA = 8, HFP = 1, HSW = 2, HBP = 1;
    localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
    localparam int CD = 2, AW = 6;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME_CLK = HT * VT * CD;
    localparam logic [13:0] IDLE = {1'b0, 6'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    logic [AW-1:0] a0, a1;
    logic          rd0, rd1;
    logic [2:0]    fd0, fd1;
    logic          r0, g0, b0, hs0, vs0, fs0, vb0;
    logic          r1, g1, b1, hs1, vs1, fs1, vb1;
    logic [2:0]    mem0 [64];
    logic [2:0]    mem1 [64];
    logic [13:0]   obs0, obs1;

    int total = 0;
    int bad   = 0;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CLK_DIV(CD), .SCALE_LOG2(0), .COLOUR_BITS(1), .SRAM_LATENCY(1), .FB_A_WIDTH(AW)
    ) dut0 (
        .clk(clk), .rst(rst), .en(en), .fb_addr(a0), .fb_rd(rd0), .fb_data(fd0),
        .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hsync(hs0), .vga_vsync(vs0),
        .frame_start(fs0), .vblank(vb0)
    );

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CLK_DIV(CD), .SCALE_LOG2(1), .COLOUR_BITS(1), .SRAM_LATENCY(1), .FB_A_WIDTH(AW)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en), .fb_addr(a1), .fb_rd(rd1), .fb_data(fd1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hsync(hs1), .vga_vsync(vs1),
        .frame_start(fs1), .vblank(vb1)
    );

    // Framebuffer SRAM models, one clk read latency.
    always @(posedge clk) begin
        if (rd0) fd0 <= mem0[a0];
        if (rd1) fd1 <= mem1[a1];
    end

    assign obs0 = {rd0, a0, r0, g0, b0, hs0, vs0, fs0, vb0};
    assign obs1 = {rd1, a1, r1, g1, b1, hs1, vs1, fs1, vb1};

    // Reference: t counts clks since scanout started (t=0 is the first clk with
    // en high). Tick k happens on clk CD*k+CD-1 and the raster position of
    // tick k is k mod (HT*VT). Outputs loaded at tick k+1 show the pixel of tick k.
    function automatic void model(input int t, input int s,
                                  output logic [13:0] e, output logic [13:0] m);
        int p, h, v, fbw, a, mm;
        logic       rd, hs, vs, fs, vb;
        logic [2:0] c;
        logic [5:0] idx;
        fbw = HA >> s;
        rd  = 1'b0;
        a   = 0;
        if (t % CD == CD - 1) begin
            p = (t / CD) % (HT * VT);
            h = p % HT;
            v = p / HT;
            if (h < HA && v < VA && (h % (1 << s)) == 0) begin
                rd = 1'b1;
                a  = (v >> s) * fbw + (h >> s);
            end
        end
        mm = t / CD;
        c  = 3'd0; hs = 1'b1; vs = 1'b1; fs = 1'b0; vb = 1'b1;
        if (mm >= 2) begin
            p = (mm - 2) % (HT * VT);
            h = p % HT;
            v = p / HT;
            if (h < HA && v < VA) begin
                idx = 6'((v >> s) * fbw + (h >> s));
                c = (s == 0) ? mem0[idx] : mem1[idx];
            end
            hs = !(h >= HA + HFP && h < HA + HFP + HSW);
            vs = !(v >= VA + VFP && v < VA + VFP + VSW);
            vb = (v >= VA);
            fs = (p == 0) && (t % CD == 0);
        end
        e = {rd, 6'(a), c, hs, vs, fs, vb};
        m = rd ? 14'h3fff : {1'b1, 6'd0, 7'h7f};
    endfunction

    // Idle for a clk, then raise en on a falling edge: that clk is t=0.
    task automatic start_run();
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (obs0 !== IDLE) begin bad++; $display("FAIL reset0 got=%h want=%h", obs0, IDLE); end
        total++;
        if (obs1 !== IDLE) begin bad++; $display("FAIL reset1 got=%h want=%h", obs1, IDLE); end
        en = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (obs0 !== IDLE) begin bad++; $display("FAIL reset_en0 got=%h want=%h", obs0, IDLE); end
        en = 1'b0;
    endtask

    task automatic test_scan(input int ncyc);
        logic [13:0] e, m;
        start_run();
        for (int t = 0; t < ncyc; t++) begin
            if (t > 0) @(negedge clk);
            model(t, 0, e, m);
            total++;
            if ((obs0 & m) !== (e & m)) begin
                bad++; $display("FAIL scan0 t=%0d got=%h want=%h", t, obs0 & m, e & m);
            end
            model(t, 1, e, m);
            total++;
            if ((obs1 & m) !== (e & m)) begin
                bad++; $display("FAIL scan1 t=%0d got=%h want=%h", t, obs1 & m, e & m);
            end
        end
    endtask

    // Runs on a free-running raster; any 2-frame window has exact counts.
    task automatic test_sync_timing();
        int   hs_low = 0, vs_low = 0, vb_hi = 0, fs_n = 0, fs_first = 0, fs_gap = 0;
        int   rd0_n = 0, rd1_n = 0, run = 0;
        logic seen_hi = 1'b0;
        logic prev_hs = 1'b1;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            @(negedge clk);
            if (!hs0) begin
                hs_low++;
                run++;
            end else begin
                if (!prev_hs && seen_hi) begin
                    total++;
                    if (run !== HSW * CD) begin
                        bad++; $display("FAIL hsync_width got=%0d want=%0d", run, HSW * CD);
                    end
                end
                run = 0;
                seen_hi = 1'b1;
            end
            prev_hs = hs0;
            if (!vs0) vs_low++;
            if (vb0) vb_hi++;
            if (rd0) rd0_n++;
            if (rd1) rd1_n++;
            if (fs0) begin
                if (fs_n == 0) fs_first = i;
                else fs_gap = i - fs_first;
                fs_n++;
            end
        end
        total++;
        if (hs_low !== 2 * VT * HSW * CD) begin bad++; $display("FAIL hsync_low got=%0d want=%0d", hs_low, 2 * VT * HSW * CD); end
        total++;
        if (vs_low !== 2 * VSW * HT * CD) begin bad++; $display("FAIL vsync_low got=%0d want=%0d", vs_low, 2 * VSW * HT * CD); end
        total++;
        if (vb_hi !== 2 * (VT - VA) * HT * CD) begin bad++; $display("FAIL vblank_len got=%0d want=%0d", vb_hi, 2 * (VT - VA) * HT * CD); end
        total++;
        if (fs_n !== 2) begin bad++; $display("FAIL fs_count got=%0d want=2", fs_n); end
        total++;
        if (fs_gap !== FRAME_CLK) begin bad++; $display("FAIL fs_period got=%0d want=%0d", fs_gap, FRAME_CLK); end
        total++;
        if (rd0_n !== 2 * VA * HA) begin bad++; $display("FAIL rd_count0 got=%0d want=%0d", rd0_n, 2 * VA * HA); end
        total++;
        if (rd1_n !== 2 * VA * (HA >> 1)) begin bad++; $display("FAIL rd_count1 got=%0d want=%0d", rd1_n, 2 * VA * (HA >> 1)); end
    endtask

    // Scoreboard of read addresses over one frame for both replication factors.
    task automatic test_addr_seq();
        logic [AW-1:0] exp0_q[$];
        logic [AW-1:0] exp1_q[$];
        logic [AW-1:0] want;
        for (int v = 0; v < VA; v++)
            for (int h = 0; h < HA; h++) begin
                exp0_q.push_back(AW'(v * HA + h));
                if (h % 2 == 0) exp1_q.push_back(AW'((v / 2) * (HA / 2) + h / 2));
            end
        start_run();
        for (int t = 0; t < FRAME_CLK; t++) begin
            if (t > 0) @(negedge clk);
            if (rd0) begin
                total++;
                if (exp0_q.size() == 0) begin
                    bad++; $display("FAIL addr0_extra got=%0d want=none", a0);
                end else begin
                    want = exp0_q.pop_front();
                    if (a0 !== want) begin bad++; $display("FAIL addr0 got=%0d want=%0d", a0, want); end
                end
            end
            if (rd1) begin
                total++;
                if (exp1_q.size() == 0) begin
                    bad++; $display("FAIL addr1_extra got=%0d want=none", a1);
                end else begin
                    want = exp1_q.pop_front();
                    if (a1 !== want) begin bad++; $display("FAIL addr1 got=%0d want=%0d", a1, want); end
                end
            end
        end
        total++;
        if (exp0_q.size() !== 0) begin bad++; $display("FAIL addr0_missing got=%0d want=0", exp0_q.size()); end
        total++;
        if (exp1_q.size() !== 0) begin bad++; $display("FAIL addr1_missing got=%0d want=0", exp1_q.size()); end
    endtask

    // Pixel (2,1) is tick 14, so its colour is driven on clks 32..33; (1,1) on 30..31.
    task automatic test_pixel_point();
        start_run();
        for (int t = 0; t <= 32; t++) begin
            if (t > 0) @(negedge clk);
            if (t == 30) begin
                total++;
                if ({r0, g0, b0} !== mem0[9]) begin bad++; $display("FAIL pix_1_1 got=%0d want=%0d", {r0, g0, b0}, mem0[9]); end
            end
            if (t == 32) begin
                total++;
                if ({r0, g0, b0} !== mem0[10]) begin bad++; $display("FAIL pix_2_1 got=%0d want=%0d", {r0, g0, b0}, mem0[10]); end
                total++;
                if ({r1, g1, b1} !== mem1[1]) begin bad++; $display("FAIL pix_2_1_s1 got=%0d want=%0d", {r1, g1, b1}, mem1[1]); end
            end
        end
    endtask

    task automatic test_en_toggle();
        logic [13:0] e, m;
        start_run();
        // Counters sit at h=5 of line 1 (tick 17) on clks 34..35.
        for (int t = 0; t <= 34; t++) begin
            if (t > 0) @(negedge clk);
            model(t, 0, e, m);
            total++;
            if ((obs0 & m) !== (e & m)) begin bad++; $display("FAIL en_pre t=%0d got=%h want=%h", t, obs0 & m, e & m); end
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (obs0 !== IDLE) begin bad++; $display("FAIL en_idle0 i=%0d got=%h want=%h", i, obs0, IDLE); end
            total++;
            if (obs1 !== IDLE) begin bad++; $display("FAIL en_idle1 i=%0d got=%h want=%h", i, obs1, IDLE); end
        end
        en = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (t > 0) @(negedge clk);
            if (t == 1) begin
                total++;
                if ({rd0, a0} !== {1'b1, 6'd0}) begin bad++; $display("FAIL en_first_rd got=%b/%0d want=1/0", rd0, a0); end
            end
            if (t == 3 || t == 4) begin
                total++;
                if (fs0 !== (t == 4)) begin bad++; $display("FAIL en_fs t=%0d got=%b want=%b", t, fs0, t == 4); end
            end
            model(t, 1, e, m);
            total++;
            if ((obs1 & m) !== (e & m)) begin bad++; $display("FAIL en_post t=%0d got=%h want=%h", t, obs1 & m, e & m); end
        end
    endtask

    task automatic test_async_reset();
        logic [13:0] e, m;
        start_run();
        for (int t = 0; t <= 70; t++) begin
            if (t > 0) @(negedge clk);
            model(t, 0, e, m);
            total++;
            if ((obs0 & m) !== (e & m)) begin bad++; $display("FAIL rst_pre t=%0d got=%h want=%h", t, obs0 & m, e & m); end
        end
        // Assert between edges and look before any further clock edge.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (obs0 !== IDLE) begin bad++; $display("FAIL rst_async0 got=%h want=%h", obs0, IDLE); end
        total++;
        if (obs1 !== IDLE) begin bad++; $display("FAIL rst_async1 got=%h want=%h", obs1, IDLE); end
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < FRAME_CLK + 40; t++) begin
            if (t > 0) @(negedge clk);
            model(t, 0, e, m);
            total++;
            if ((obs0 & m) !== (e & m)) begin bad++; $display("FAIL rst_post0 t=%0d got=%h want=%h", t, obs0 & m, e & m); end
            model(t, 1, e, m);
            total++;
            if ((obs1 & m) !== (e & m)) begin bad++; $display("FAIL rst_post1 t=%0d got=%h want=%h", t, obs1 & m, e & m); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem0[i] = 3'($urandom_range(0, 7));
            mem1[i] = 3'($urandom_range(0, 7));
        end
        test_reset();
        test_scan(2 * FRAME_CLK + 64);
        test_sync_timing();
        test_addr_seq();
        test_pixel_point();
        test_en_toggle();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Parametrised VGA timing generator and framebuffer scanout engine. Generalises the fixed 640x480, 1-bit-per-channel output to configurable timing, colour depth and integer pixel replication.
- Sits between the framebuffer SRAM (an `inferred_sram` instance) read port and the top-level VGA pins.
- Derives the pixel rate from `clk` via a clock-enable divider.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel; 50 MHz / 2 = 25 MHz
- SCALE_LOG2, 2, each framebuffer pixel is replicated 2^S x 2^S
- COLOUR_BITS, 1, bits per colour channel
- SRAM_LATENCY, 1, clk cycles from fb_rd to valid fb_data; must be <= CLK_DIV-1
- FB_A_WIDTH, 15, framebuffer address width; must hold (H_ACTIVE>>S)*(V_ACTIVE>>S)

Ports:
- clk, in, 1, system clock (50 MHz)
- rst, in, 1, asynchronous active-high reset
- en, in, 1, scanout enable
- fb_addr, out, FB_A_WIDTH, framebuffer read address
- fb_rd, out, 1, framebuffer read strobe
- fb_data, in, 3*COLOUR_BITS, pixel {r,g,b}; valid SRAM_LATENCY cycles after fb_rd
- vga_r, vga_g, vga_b, out, COLOUR_BITS each, colour outputs; zero when blanked
- vga_hsync, vga_vsync, out, 1 each, active-low syncs
- frame_start, out, 1, one-clk pulse when the pixel at (0,0) is driven
- vblank, out, 1, high while outputs are in vertical blanking

Behaviour:
- Reset values:
  - all counters = 0, fb_addr = 0
  - fb_rd = 0, colours = 0, frame_start = 0
  - vga_hsync = vga_vsync = 1
  - vblank = 1
- Pixel tick: a divider counts 0..CLK_DIV-1; tick asserts when the divider = CLK_DIV-1. All timing state advances only on tick.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters.
  - At wrap, h_cnt returns to 0 and v_cnt increments.
  - v_cnt wraps 0..V_TOTAL-1.
- Visible regions:
  - Active when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - hsync region: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync region is analogous.
- Address generation (no multiplier):
  - line_base: reset to 0 at frame start. At the end of each active line where the low S bits of v_cnt are all ones, add FB_W = H_ACTIVE>>S to line_base.
  - col: increments on tick when active and the low S bits of h_cnt are all ones; reset to 0 at line wrap.
  - fb_addr = line_base + col.
- Reads:
  - fb_rd pulses for one clk on the tick cycle for active pixels whose low S bits of h_cnt = 0. This gives one read per replicated group; no reads occur in blanking.
  - SRAM_LATENCY clk cycles after fb_rd, fb_data is captured into a pixel latch.
  - The latch holds for the remaining 2^S-1 replicated pixels.
- Output stage:
  - Registered on tick, driven from counter state delayed by one pixel tick.
  - Fixed latency: the outputs for pixel (h,v) appear one tick after the counters were at (h,v).
  - hsync, vsync and vblank pass through the same one-tick delay so they stay aligned with colour.
  - Colour is forced to 0 when the delayed pixel is not active.
- frame_start: pulses for exactly one clk, on the tick at which the delayed pixel is (0,0).
- en low:
  - Divider and counters are held at 0 and line_base is held at 0; fb_rd = 0.
  - Outputs return to reset values on the next clk.
  - When en rises, scanout starts at (0,0) and frame_start follows after the one-tick latency.
- Reset mid-frame: all state clears immediately (async). Scanout restarts at (0,0) after release; no partial-line recovery.
- Simultaneous h and v wrap: v_cnt returns to 0, line_base returns to 0, and col returns to 0 in the same tick.

Decomposition:
- Shared package `vga_pkg`:
  - struct vga_timing_t (active/fp/sync/bp) with a 640x480@60 localparam constant
  - typedef rgb_t, packed {r,g,b}
- Natural sub-module `vga_axis_counter`:
  - one instance per axis
  - parametrised active/fp/sync/bp; inputs advance and en
  - outputs cnt, active, sync, wrap

Test Plan:
- Small timing (H 8/1/2/1, V 4/1/1/1, CLK_DIV 2, S 0): hsync low for exactly 4 clk per 24-clk line; vsync low for 1 line per 7-line frame; frame_start period 168 clk.
- Same timing: fb_data = fb_addr[2:0] model with SRAM_LATENCY 1. fb_addr sequence 0..7 then 8..15; {r,g,b} at the 3rd pixel of line 1 equals data for address 10, appearing one tick after the counters reach it.
- S=1, H_ACTIVE 8: only 4 fb_rd per active line; each colour is held for 2 pixels; line_base advances by 4 only every 2nd line (addresses 0,1,2,3 repeated on line 1).
- Blanking: during porch/sync the colours are 0 and fb_rd is never asserted; vblank is high exactly on lines 4..6.
- en dropped mid-line at h=5 and raised 10 clk later: outputs idle (syncs=1, colour=0) while low; after rise, the first fb_addr is 0 and frame_start pulses after one tick.
- rst asserted asynchronously mid-frame: outputs reach reset values without waiting for a clk edge; after release, the counters restart from (0,0) with full timing intact.
